punch_lane_engine: RTL



---
 rtl/punch_lane_engine_pkg.sv | 25 ++
 rtl/punch_lane_engine_lane_queue.sv | 36 +++
 rtl/punch_lane_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/punch_lane_engine_pkg.sv
// Shared types for the punch lane engine: FSM states, queue slot layout, lane colours.
package punch_lane_engine_pkg;

  localparam int unsigned LaneW = 2;

  typedef enum logic [1:0] {StIdle, StFill, StPlay, StOver} state_e;

  typedef struct packed {
    logic             valid;
    logic [LaneW-1:0] lane;
  } slot_t;

  // {r, g, b} for each lane
  function automatic logic [2:0] lane_rgb(input logic [LaneW-1:0] lane);
    logic [2:0] rgb;
    unique case (lane)
      2'd0:    rgb = 3'b110;
      2'd1:    rgb = 3'b001;
      2'd2:    rgb = 3'b010;
      default: rgb = 3'b101;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/punch_lane_engine_lane_queue.sv
// Monster queue: SLOTS-entry shift register, slot 0 is the front, new entries enter at the tail.
module lane_queue
  import punch_lane_engine_pkg::*;
#(
  parameter int unsigned SLOTS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift,
  input  logic                  wr_en,
  input  slot_t                 wr_slot,
  output slot_t [SLOTS-1:0]     slots
);

  slot_t [SLOTS-1:0] slots_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_q <= '0;
    end else if (clear) begin
      slots_q <= '0;
    end else if (shift) begin
      for (int unsigned i = 0; i < SLOTS - 1; i++) begin
        slots_q[i] <= slots_q[i+1];
      end
      // A shift empties the tail unless a value is written in the same cycle
      slots_q[SLOTS-1] <= wr_en ? wr_slot : '0;
    end else if (wr_en) begin
      slots_q[SLOTS-1] <= wr_slot;
    end
  end

  assign slots = slots_q;

endmodule

// File: rtl/punch_lane_engine.sv
// N-lane punch game core: queue fill/refill handshake, hit/miss scoring, timeout speed-up
// and registered HUB75 pixel lookup.
module punch_lane_engine
  import punch_lane_engine_pkg::*;
#(
  parameter int unsigned LANES        = 3,
  parameter int unsigned SLOTS        = 6,
  parameter int unsigned SLOT_W       = 10,
  parameter int unsigned ROWS         = 32,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned TIMEOUT0     = 50000000,
  parameter int unsigned TIMEOUT_MIN  = 10000000,
  parameter int unsigned TIMEOUT_STEP = 1000000,
  parameter int unsigned SCORE_W      = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LANES-1:0]                  btn,
  input  logic [1:0]                        rand_lane,
  input  logic                              rand_valid,
  output logic                              rand_req,
  input  logic [$clog2(ROWS/2)-1:0]         row,
  input  logic [$clog2(SLOTS*SLOT_W)-1:0]   col,
  output logic                              r0,
  output logic                              g0,
  output logic                              b0,
  output logic                              r1,
  output logic                              g1,
  output logic                              b1,
  output logic [SCORE_W-1:0]                score,
  output logic [$clog2(LIVES+1)-1:0]        lives,
  output logic                              gameover,
  output logic                              hit_pulse,
  output logic                              miss_pulse
);

  localparam int unsigned LivesW = $clog2(LIVES + 1);
  localparam int unsigned TimerW = $clog2(TIMEOUT0 + 1);
  localparam int unsigned CntW   = $clog2(SLOTS + 1);
  localparam int unsigned Band   = ROWS / LANES;
  localparam int unsigned Half   = ROWS / 2;

  state_e              state_q, state_d;
  slot_t [SLOTS-1:0]   slots;
  slot_t               front, wr_slot, sel;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LivesW-1:0]   lives_q, lives_d;
  logic [TimerW-1:0]   cur_timeout_q, cur_timeout_d, timer_q, timer_d, next_to;
  logic [CntW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [LANES-1:0]    btn_q, edges;
  logic                pending_q, pending_d, hit_q, miss_q;
  logic [5:0]          pix_q, pix_d;
  logic                start_game, xfer, fill_xfer, fill_last, play_active, hit_match;
  logic                do_hit, do_wrong, do_miss, do_gap, shift;

  assign front       = slots[0];
  assign edges       = btn & ~btn_q;
  assign xfer        = rand_req & rand_valid;
  assign start_game  = start && (state_q == StIdle || state_q == StOver);
  assign fill_xfer   = (state_q == StFill) && xfer;
  assign fill_last   = fill_xfer && (fill_cnt_q == CntW'(SLOTS - 1));
  // Gameplay decisions are frozen while a refill is outstanding or once lives are exhausted
  assign play_active = (state_q == StPlay) && (lives_q != '0) && !pending_q;
  assign hit_match   = edges == (LANES'(1) << front.lane);
  assign do_hit      = play_active && front.valid && (edges != '0) && hit_match;
  assign do_wrong    = play_active && front.valid && (edges != '0) && !hit_match;
  assign do_miss     = play_active && front.valid && (edges == '0) && (timer_q == '0);
  assign do_gap      = play_active && !front.valid;
  assign shift       = fill_xfer || do_hit || do_miss || do_gap;
  assign wr_slot     = '{valid: 32'(rand_lane) < LANES, lane: rand_lane};

  assign next_to = (32'(cur_timeout_q) >= TIMEOUT_MIN + TIMEOUT_STEP) ?
                   TimerW'(32'(cur_timeout_q) - TIMEOUT_STEP) : TimerW'(TIMEOUT_MIN);

  lane_queue #(
    .SLOTS(SLOTS)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_game),
    .shift   (shift),
    .wr_en   (xfer),
    .wr_slot (wr_slot),
    .slots   (slots)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFill;
      StFill:  if (fill_last) state_d = StPlay;
      StPlay:  if (lives_q == '0) state_d = StOver;
      StOver:  if (start) state_d = StFill;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rand_req = 1'b0;
    gameover = 1'b0;
    unique case (state_q)
      StFill:  rand_req = 1'b1;
      StPlay:  rand_req = pending_q;
      StOver:  gameover = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    score_d       = score_q;
    lives_d       = lives_q;
    cur_timeout_d = cur_timeout_q;
    timer_d       = timer_q;
    fill_cnt_d    = fill_cnt_q;
    pending_d     = pending_q;
    if (start_game) begin
      score_d       = '0;
      lives_d       = LivesW'(LIVES);
      cur_timeout_d = TimerW'(TIMEOUT0);
      fill_cnt_d    = '0;
      pending_d     = 1'b0;
    end
    if (fill_xfer) fill_cnt_d = fill_cnt_q + CntW'(1);
    if ((state_q == StPlay) && xfer) pending_d = 1'b0;
    if (do_hit || do_miss || do_gap) pending_d = 1'b1;
    if (do_hit && (score_q != '1)) score_d = score_q + SCORE_W'(1);
    if (do_hit) cur_timeout_d = next_to;
    if (do_wrong || do_miss) lives_d = lives_q - LivesW'(1);
    // A press in the expiry cycle wins, so a wrong press leaves the timer at 0 to expire next
    if (fill_last)                timer_d = cur_timeout_q;
    else if (do_hit)              timer_d = next_to;
    else if (do_miss || do_gap)   timer_d = cur_timeout_q;
    else if (play_active && (timer_q != '0)) timer_d = timer_q - TimerW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q       <= '0;
      lives_q       <= LivesW'(LIVES);
      cur_timeout_q <= TimerW'(TIMEOUT0);
      timer_q       <= '0;
      fill_cnt_q    <= '0;
      pending_q     <= 1'b0;
      btn_q         <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      pix_q         <= '0;
    end else begin
      score_q       <= score_d;
      lives_q       <= lives_d;
      cur_timeout_q <= cur_timeout_d;
      timer_q       <= timer_d;
      fill_cnt_q    <= fill_cnt_d;
      pending_q     <= pending_d;
      btn_q         <= btn;
      hit_q         <= do_hit;
      miss_q        <= do_wrong || do_miss;
      pix_q         <= pix_d;
    end
  end

  function automatic logic row_lit(input int unsigned p, input slot_t s);
    int unsigned off;
    off = p % Band;
    return s.valid && (p < LANES * Band) && (32'(s.lane) == p / Band) &&
           (off >= 1) && (off <= Band - 2);
  endfunction

  always_comb begin
    int unsigned slot_idx, xo;
    logic        x_ok;
    slot_idx = 32'(col) / SLOT_W;
    xo       = 32'(col) % SLOT_W;
    x_ok     = (xo >= 1) && (xo <= SLOT_W - 2);
    sel      = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (slot_idx == i) sel = slots[i];
    end
    pix_d = '0;
    if (x_ok && (state_q != StOver)) begin
      if (row_lit(32'(row), sel))        pix_d[5:3] = lane_rgb(sel.lane);
      if (row_lit(32'(row) + Half, sel)) pix_d[2:0] = lane_rgb(sel.lane);
    end
  end

  assign {r0, g0, b0, r1, g1, b1} = pix_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule
